// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 frame receiver with make/break scan-code decoder
module ps2_key_decoder #(
   parameter int           SYNC_STAGES = 2,
   parameter int           TIMEOUT_CYC = 4000,
   parameter logic [7:0]   REL_CODE    = 8'h70
) (
   input  logic            CLK_20M,
   input  logic            RST,
   input  logic            PS2_CLK,
   input  logic            PS2_DAT,
   output logic [7:0]      KEY,
   output logic            KEY_VALID,
   output logic [7:0]      RX_BYTE,
   output logic            RX_STB,
   output logic            ERR
);

   localparam int TCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } rx_state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   dat_s;
   logic                   fall;

   rx_state_t              rx_state;
   logic [2:0]             bitcnt;
   logic [7:0]             shreg;
   logic                   par_bit;
   logic [TCW-1:0]         tcnt;

   logic                   brk;
   logic                   ext;
   logic [7:0]             last_key;

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];
   assign fall  = clk_prev & ~clk_s;

   // Bring both keyboard pins into the system clock domain; idle-high preset avoids a false edge at reset
   always_ff @(posedge CLK_20M) begin
      if (RST) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
         clk_prev <= clk_s;
      end
   end

   // Frame receiver: start, 8 data LSB-first, odd parity, stop, with a mid-frame inactivity abort
   always_ff @(posedge CLK_20M) begin
      if (RST) begin
         rx_state <= S_IDLE;
         bitcnt   <= 3'd0;
         shreg    <= 8'h00;
         par_bit  <= 1'b0;
         tcnt     <= '0;
         RX_BYTE  <= 8'h00;
         RX_STB   <= 1'b0;
         ERR      <= 1'b0;
      end else begin
         RX_STB <= 1'b0;
         ERR    <= 1'b0;
         if (rx_state == S_IDLE) begin
            tcnt <= '0;
            // a high level on the start-bit edge is treated as a glitch and ignored
            if (fall && !dat_s) begin
               rx_state <= S_DATA;
               bitcnt   <= 3'd0;
            end
         end else if (fall) begin
            tcnt <= '0;
            case (rx_state)
               S_DATA: begin
                  shreg[bitcnt] <= dat_s;
                  if (bitcnt == 3'd7) begin
                     rx_state <= S_PARITY;
                  end else begin
                     bitcnt <= bitcnt + 3'd1;
                  end
               end
               S_PARITY: begin
                  par_bit  <= dat_s;
                  rx_state <= S_STOP;
               end
               default: begin
                  if (dat_s && (^{shreg, par_bit})) begin
                     RX_BYTE <= shreg;
                     RX_STB  <= 1'b1;
                  end else begin
                     ERR <= 1'b1;
                  end
                  rx_state <= S_IDLE;
               end
            endcase
         end else if (tcnt == TC_LAST) begin
            rx_state <= S_IDLE;
            tcnt     <= '0;
            ERR      <= 1'b1;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

   // Scan-code decoder: track break/extended prefixes and publish the single held key
   always_ff @(posedge CLK_20M) begin
      if (RST) begin
         brk       <= 1'b0;
         ext       <= 1'b0;
         last_key  <= REL_CODE;
         KEY       <= REL_CODE;
         KEY_VALID <= 1'b0;
      end else begin
         KEY_VALID <= 1'b0;
         if (RX_STB) begin
            if (RX_BYTE == 8'hF0) begin
               brk <= 1'b1;
            end else if (RX_BYTE == 8'hE0) begin
               ext <= 1'b1;
            end else if (ext) begin
               // extended keys are not routed to the tone stage
               brk <= 1'b0;
               ext <= 1'b0;
            end else if (brk) begin
               brk <= 1'b0;
               // releasing a key other than the held one leaves the tone running
               if (RX_BYTE == last_key) begin
                  KEY       <= REL_CODE;
                  last_key  <= REL_CODE;
                  KEY_VALID <= 1'b1;
               end
            end else if (RX_BYTE != last_key) begin
               // typematic repeats of the held key are suppressed
               KEY       <= RX_BYTE;
               last_key  <= RX_BYTE;
               KEY_VALID <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT_CYC = 4000;
   localparam int HALF        = 10;

   logic       CLK_20M = 1'b0;
   logic       RST;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [7:0] KEY;
   logic       KEY_VALID;
   logic [7:0] RX_BYTE;
   logic       RX_STB;
   logic       ERR;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rx_cyc = -10;
   int err_cyc = 0;
   int last_fall_cyc = 0;
   int exp_err_pending = 0;

   logic [7:0] exp_rx[$];
   logic [7:0] exp_key[$];

   ps2_key_decoder #(
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .REL_CODE    (8'h70)
   ) dut (
      .CLK_20M   (CLK_20M),
      .RST       (RST),
      .PS2_CLK   (PS2_CLK),
      .PS2_DAT   (PS2_DAT),
      .KEY       (KEY),
      .KEY_VALID (KEY_VALID),
      .RX_BYTE   (RX_BYTE),
      .RX_STB    (RX_STB),
      .ERR       (ERR)
   );

   always #25 CLK_20M = ~CLK_20M;

   always @(posedge CLK_20M) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop the scoreboard whenever the DUT strobes
   always @(negedge CLK_20M) begin
      if (RX_STB === 1'b1 && ERR === 1'b1) check("strobes_exclusive", 1, 0);
      if (RX_STB === 1'b1) begin
         rx_cyc = cyc;
         if (exp_rx.size() == 0) check("unexpected_rx_stb", {24'h0, RX_BYTE}, 32'hFFFF_FFFF);
         else check("rx_byte", {24'h0, RX_BYTE}, {24'h0, exp_rx.pop_front()});
      end
      if (ERR === 1'b1) begin
         err_cyc = cyc;
         if (exp_err_pending == 0) check("unexpected_err", 1, 0);
         else begin
            check("err_expected", 1, 1);
            exp_err_pending--;
         end
      end
      if (KEY_VALID === 1'b1) begin
         check("key_latency", cyc, rx_cyc + 1);
         if (exp_key.size() == 0) check("unexpected_key_valid", {24'h0, KEY}, 32'hFFFF_FFFF);
         else check("key", {24'h0, KEY}, {24'h0, exp_key.pop_front()});
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int nbits);
      logic [10:0] fr;
      fr = {stp, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge CLK_20M) PS2_DAT = fr[i];
         repeat (HALF) @(negedge CLK_20M);
         PS2_CLK = 1'b0;
         last_fall_cyc = cyc;
         repeat (HALF) @(negedge CLK_20M);
         PS2_CLK = 1'b1;
      end
      PS2_DAT = 1'b1;
      repeat (6) @(negedge CLK_20M);
   endtask

   task automatic send_good(input logic [7:0] b);
      exp_rx.push_back(b);
      send_frame(b, ~^b, 1'b1, 11);
   endtask

   task automatic do_reset(input int n);
      @(negedge CLK_20M) RST = 1'b1;
      repeat (n) @(negedge CLK_20M);
      RST = 1'b0;
   endtask

   initial begin
      RST     = 1'b1;
      PS2_CLK = 1'b0;
      PS2_DAT = 1'b1;
      repeat (3) @(posedge CLK_20M);
      @(negedge CLK_20M);
      check("reset_key", {24'h0, KEY}, 32'h70);
      check("reset_rx_byte", {24'h0, RX_BYTE}, 32'h0);
      check("reset_strobes", {29'h0, KEY_VALID, RX_STB, ERR}, 32'h0);
      RST = 1'b0;
      repeat (10) @(negedge CLK_20M);
      PS2_CLK = 1'b1;
      repeat (10) @(negedge CLK_20M);
      check("post_reset_key", {24'h0, KEY}, 32'h70);

      // first frame after reset
      exp_key.push_back(8'h69);
      send_good(8'h69);
      check("key_after_69", {24'h0, KEY}, 32'h69);

      // make / typematic / break
      do_reset(2);
      exp_key.push_back(8'h69);
      exp_key.push_back(8'h70);
      send_good(8'h69);
      send_good(8'h69);
      send_good(8'h69);
      send_good(8'hF0);
      send_good(8'h69);
      check("key_after_break", {24'h0, KEY}, 32'h70);

      // rollover: break of non-held key is ignored
      exp_key.push_back(8'h72);
      exp_key.push_back(8'h7A);
      exp_key.push_back(8'h70);
      send_good(8'h72);
      send_good(8'h7A);
      send_good(8'hF0);
      send_good(8'h72);
      check("key_rollover_mid", {24'h0, KEY}, 32'h7A);
      send_good(8'hF0);
      send_good(8'h7A);

      // extended make and break are not routed
      send_good(8'hE0);
      send_good(8'h75);
      send_good(8'hE0);
      send_good(8'hF0);
      send_good(8'h75);
      check("key_after_ext", {24'h0, KEY}, 32'h70);

      // parity error: 8'h73 has five ones, so parity 1 is wrong
      exp_err_pending++;
      send_frame(8'h73, 1'b1, 1'b1, 11);
      // stop-bit error
      exp_err_pending++;
      send_frame(8'h74, ~^8'h74, 1'b0, 11);
      check("key_after_errs", {24'h0, KEY}, 32'h70);

      // timeout: start + 4 data bits then silence
      exp_err_pending++;
      err_cyc = 0;
      send_frame(8'h55, 1'b1, 1'b1, 5);
      for (int i = 0; i < TIMEOUT_CYC + 200 && err_cyc == 0; i++) @(negedge CLK_20M);
      check("timeout_seen", (err_cyc != 0), 1);
      check("timeout_delay", err_cyc - last_fall_cyc, SYNC_STAGES + 1 + TIMEOUT_CYC);

      // recovery after timeout
      exp_key.push_back(8'h74);
      send_good(8'h74);
      check("key_after_recovery", {24'h0, KEY}, 32'h74);

      // reset mid-frame discards it
      send_frame(8'h1C, ~^8'h1C, 1'b1, 4);
      do_reset(3);
      repeat (10) @(negedge CLK_20M);
      check("key_after_midframe_reset", {24'h0, KEY}, 32'h70);
      exp_key.push_back(8'h1C);
      send_good(8'h1C);
      check("key_after_reset_frame", {24'h0, KEY}, 32'h1C);

      repeat (20) @(negedge CLK_20M);
      check("rx_queue_empty", exp_rx.size(), 0);
      check("key_queue_empty", exp_key.size(), 0);
      check("err_pending_empty", exp_err_pending, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream stage of the keypad tone generator. Receives PS/2 keyboard frames on PS2_CLK/PS2_DAT and checks framing and parity.
- Strips make/break/extended prefixes and presents a held scan code on KEY[7:0].
- Releasing the held key drives KEY to REL_CODE (keypad 0, 8'h70), which the tone stage decodes as silence.
- Also exposes every raw received byte (RX_BYTE/RX_STB) for the LCD display path.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchronisers on PS2_CLK and PS2_DAT (minimum 2).
- TIMEOUT_CYC, 4000: CLK_20M cycles without a PS2_CLK falling edge mid-frame before the frame is aborted (200 us at 20 MHz).
- REL_CODE, 8'h70: code driven on KEY at reset and on release of the held key.

Ports:
- CLK_20M  input  1  system clock, 20 MHz; the only clock.
- RST  input  1  reset, synchronous, active-high.
- PS2_CLK  input  1  keyboard clock, asynchronous, idle high.
- PS2_DAT  input  1  keyboard data, asynchronous, idle high.
- KEY  output  8  currently held scan code, or REL_CODE.
- KEY_VALID  output  1  one-cycle strobe; KEY changed this cycle.
- RX_BYTE  output  8  last correctly received byte, raw.
- RX_STB  output  1  one-cycle strobe; RX_BYTE updated.
- ERR  output  1  one-cycle strobe; parity, stop-bit or timeout error.

Behaviour:
- Clock and reset: single clock CLK_20M. RST is synchronous, active-high, sampled on the CLK_20M rising edge.
- Reset values:
  - KEY = REL_CODE.
  - KEY_VALID = RX_STB = ERR = 0.
  - RX_BYTE = 8'h00.
  - Both FSMs in IDLE/NORMAL; all flags and counters cleared.
  - last_key = REL_CODE.
  - Synchroniser flops preset to 1.
- Reset priority: RST wins over any simultaneous event. A frame in progress at reset is discarded with no strobes.
- Input sampling: both pins pass through SYNC_STAGES flops. fall = (prev synced PS2_CLK == 1) && (synced PS2_CLK == 0). Data is sampled from the synced PS2_DAT in the fall cycle.
- Receive FSM:
  - Frame format, 11 bits: start (0), 8 data LSB-first, odd parity, stop (1).
  - IDLE: on fall with data == 0, go to DATA with bitcnt = 0. On fall with data == 1, stay in IDLE with no error (glitch ignored).
  - DATA: each fall shifts data into bit[bitcnt]. After bit 7, go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, good frame = (stop == 1) && (^{data, parity} == 1).
    - Good frame: RX_BYTE <= data and RX_STB = 1 in the next cycle.
    - Bad frame: ERR = 1 in the next cycle; byte discarded.
    - Either way, return to IDLE.
- Timeout:
  - Counter runs whenever the FSM is not in IDLE and clears on every fall.
  - When it reaches TIMEOUT_CYC - 1: go to IDLE and pulse ERR for one cycle.
  - No timeout runs in IDLE.
- Decoder: consumes each good byte b in the cycle RX_STB is high; all KEY effects appear one cycle after RX_STB.
  - b == 8'hF0: set brk. No output.
  - b == 8'hE0: set ext. No output.
  - Other b with ext set: ignored (extended keys not routed). Clear brk and ext.
  - Other b with brk set and b == last_key: KEY <= REL_CODE, last_key <= REL_CODE, KEY_VALID pulse. Clear brk and ext.
  - Other b with brk set and b != last_key: ignored (release of a non-held key). Clear brk.
  - Make with b != last_key: KEY <= b, last_key <= b, KEY_VALID pulse.
  - Make with b == last_key (typematic repeat): no change, no pulse.
- Latency: stop-bit fall at cycle N gives RX_STB/ERR at N+1 and KEY/KEY_VALID at N+2. Pin edge to fall is SYNC_STAGES+1 cycles.
- Strobes:
  - Strobes are never stretched.
  - ERR and RX_STB are mutually exclusive in any cycle.
  - Flags brk and ext persist across bytes until consumed. They are not cleared by ERR.

Test Plan:
- Reset: hold RST 3 cycles with PS2_CLK low -> KEY = 8'h70, all strobes 0, no ERR after release. Then send frame 8'h69 -> RX_STB with RX_BYTE = 8'h69; KEY = 8'h69 with one KEY_VALID pulse 1 cycle later.
- Make/repeat/break: send 69, 69, 69, F0, 69 -> exactly two KEY_VALID pulses: KEY = 8'h69, then KEY = 8'h70. Five RX_STB pulses.
- Key rollover: send 72, 7A, F0 72, F0 7A -> KEY sequence 72, 7A, 70. Break of 72 produces no KEY_VALID.
- Extended and errors:
  - Send E0 75, then E0 F0 75 -> KEY stays 8'h70, no KEY_VALID.
  - Frame 8'h73 with even parity -> ERR pulse, no RX_STB, KEY unchanged.
  - Frame with stop = 0 -> ERR pulse.
- Timeout and recovery:
  - Stop PS2_CLK after 5 bits -> ERR exactly TIMEOUT_CYC cycles after last fall, FSM in IDLE.
  - Next full frame 8'h74 is received correctly.
  - Assert RST mid-frame -> no strobes, KEY = 8'h70.
